act_stream_framer: RTL and testbench

Downstream neighbour of the elementwise activation stage (HardTanh and siblings). Buffers the 32-bit activation output stream in a small first-word-fall-through FIFO and adds valid/ready backpressure, which the activation stage lacks. Tags the final element of each tensor frame with last_out and counts completed frames, so the writeback stage sees framed, flow-controlled tensors.

---
 rtl/act_stream_pkg.sv | 14 +
 rtl/act_fwft_fifo.sv | 66 ++++++
 rtl/act_stream_framer.sv | 111 +++++++++++
 tb/tb_act_stream_framer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/act_stream_pkg.sv
// Shared definitions for the activation-stage stream blocks: default element width,
// element type and FIFO occupancy-width helper.
package act_stream_pkg;

  localparam int unsigned DefaultDataW = 32;

  typedef logic [DefaultDataW-1:0] elem_t;

  // Occupancy counters must represent 0..depth inclusive.
  function automatic int unsigned occ_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/act_fwft_fifo.sv
// First-word-fall-through FIFO with valid/ready on both sides; head entry is always
// visible on rd_data_o, and write-side ready depends only on registered occupancy.
module act_fwft_fifo
  import act_stream_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_valid_i,
  output logic                      wr_ready_o,
  input  logic [DATA_W-1:0]         wr_data_i,
  output logic                      rd_valid_o,
  input  logic                      rd_ready_i,
  output logic [DATA_W-1:0]         rd_data_o,
  output logic [occ_w(DEPTH)-1:0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = occ_w(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              wr_en, rd_en;

  assign wr_ready_o = (count_q < CntW'(DEPTH));
  assign rd_valid_o = (count_q != '0);
  assign wr_en      = wr_valid_i & wr_ready_o;
  assign rd_en      = rd_valid_o & rd_ready_i;
  assign rd_data_o  = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  // Pointers are exactly log2(DEPTH) wide, so increments wrap on their own.
  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (wr_en) begin
        mem_q[wr_ptr_q] <= wr_data_i;
      end
    end
  end

endmodule

// File: rtl/act_stream_framer.sv
// Buffers the activation output stream, adds backpressure and frames it into tensors.
// Optional high-water mark on FIFO occupancy when ACT_STREAM_FRAMER_HWM_EN is defined.
module act_stream_framer
  import act_stream_pkg::*;
#(
  parameter int unsigned DATA_W    = DefaultDataW,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned FRAME_LEN = 256,
  parameter int unsigned FCNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic [DATA_W-1:0]       input_data,
  output logic                    valid_out,
  input  logic                    ready_out,
  output logic [DATA_W-1:0]       output_data,
  output logic                    last_out,
  output logic                    frame_done,
  output logic [FCNT_W-1:0]       frame_count,
`ifdef ACT_STREAM_FRAMER_HWM_EN
  input  logic                    hwm_clr,
  output logic [occ_w(DEPTH)-1:0] hwm,
  output logic [occ_w(DEPTH)-1:0] fifo_count
`else
  output logic [occ_w(DEPTH)-1:0] fifo_count
`endif
);

  localparam int unsigned IdxW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(FRAME_LEN - 1);

  logic              rd_en;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              frame_done_q, frame_done_d;
  logic [FCNT_W-1:0] frame_count_q, frame_count_d;

  act_fwft_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid_i (valid_in),
    .wr_ready_o (ready_in),
    .wr_data_i  (input_data),
    .rd_valid_o (valid_out),
    .rd_ready_i (ready_out),
    .rd_data_o  (output_data),
    .count_o    (fifo_count)
  );

  assign rd_en    = valid_out & ready_out;
  assign last_out = valid_out & (idx_q == IdxLast);

  always_comb begin
    idx_d         = idx_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    if (rd_en) begin
      if (last_out) begin
        idx_d         = '0;
        frame_done_d  = 1'b1;
        frame_count_d = frame_count_q + 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q         <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      idx_q         <= idx_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;

`ifdef ACT_STREAM_FRAMER_HWM_EN
  logic [occ_w(DEPTH)-1:0] hwm_q, hwm_d;

  // Tracks registered occupancy; a clear reloads from the current count, not zero.
  always_comb begin
    hwm_d = hwm_q;
    if (hwm_clr) begin
      hwm_d = fifo_count;
    end else if (fifo_count > hwm_q) begin
      hwm_d = fifo_count;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hwm_q <= '0;
    end else begin
      hwm_q <= hwm_d;
    end
  end

  assign hwm = hwm_q;
`endif

endmodule

// File: tb/tb_act_stream_framer.sv
// Scoreboard bench for act_stream_framer: driver pushes expected elements on accept,
// a negedge monitor checks order, data, framing, occupancy and stability.
module tb_act_stream_framer;
  import act_stream_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned FL    = 4;

  typedef struct {
    elem_t data;
    bit    last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid_in = 1'b0;
  logic        ready_in;
  elem_t       input_data = '0;
  logic        valid_out;
  logic        ready_out = 1'b0;
  elem_t       output_data;
  logic        last_out;
  logic        frame_done;
  logic [15:0] frame_count;
  logic [3:0]  fifo_count;
`ifdef ACT_STREAM_FRAMER_HWM_EN
  logic        hwm_clr = 1'b0;
  logic [3:0]  hwm;
`endif

  act_stream_framer #(
    .DATA_W    (32),
    .DEPTH     (DEPTH),
    .FRAME_LEN (FL),
    .FCNT_W    (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_in    (valid_in),
    .ready_in    (ready_in),
    .input_data  (input_data),
    .valid_out   (valid_out),
    .ready_out   (ready_out),
    .output_data (output_data),
    .last_out    (last_out),
    .frame_done  (frame_done),
    .frame_count (frame_count),
`ifdef ACT_STREAM_FRAMER_HWM_EN
    .hwm_clr     (hwm_clr),
    .hwm         (hwm),
`endif
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   wr_ord = 0;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: reference model of occupancy and framing, evaluated on the falling edge.
  int    occ_m = 0;
  int    frames_m = 0;
  bit    fd_exp = 0;
  int    hwm_m = 0;
  bit    prev_stall = 0;
  elem_t prev_data = '0;
  bit    prev_last = 0;

  always @(negedge clk) begin
    exp_t it;
    bit   rd, wr;
    if (!rst_n) begin
      occ_m = 0; frames_m = 0; fd_exp = 0; hwm_m = 0; prev_stall = 0;
    end else begin
      chk("fifo_count", 64'(fifo_count), 64'(occ_m));
      chk("ready_in", 64'(ready_in), 64'(occ_m < int'(DEPTH)));
      chk("valid_out", 64'(valid_out), 64'(occ_m != 0));
      chk("frame_done", 64'(frame_done), 64'(fd_exp));
      chk("frame_count", 64'(frame_count), 64'(frames_m));
`ifdef ACT_STREAM_FRAMER_HWM_EN
      chk("hwm", 64'(hwm), 64'(hwm_m));
`endif
      if (prev_stall && valid_out) begin
        chk("stall_data", 64'(output_data), 64'(prev_data));
        chk("stall_last", 64'(last_out), 64'(prev_last));
      end
      if (occ_m != 0) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_empty", 64'(valid_out), 64'(0));
        end else begin
          chk("output_data", 64'(output_data), 64'(exp_q[0].data));
          chk("last_out", 64'(last_out), 64'(exp_q[0].last));
        end
      end else begin
        chk("last_out_idle", 64'(last_out), 64'(0));
      end
      rd = (occ_m != 0) && ready_out;
      wr = valid_in && (occ_m < int'(DEPTH));
      fd_exp = 0;
      if (rd && exp_q.size() > 0) begin
        it = exp_q.pop_front();
        if (it.last) begin
          frames_m++;
          fd_exp = 1;
        end
      end
`ifdef ACT_STREAM_FRAMER_HWM_EN
      hwm_m = hwm_clr ? occ_m : ((occ_m > hwm_m) ? occ_m : hwm_m);
`endif
      occ_m = occ_m + int'(wr) - int'(rd);
      prev_stall = valid_out && !ready_out;
      prev_data  = output_data;
      prev_last  = last_out;
    end
  end

  // Driver helpers: inputs change 2 time units after the rising edge.
  task automatic step(output bit acc);
    @(negedge clk);
    acc = valid_in && ready_in && rst_n;
    if (acc) begin
      exp_q.push_back('{data: input_data, last: (wr_ord % FL) == FL - 1});
      wr_ord++;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic send(input elem_t d, input int rmode, output int cycles);
    bit acc;
    acc = 0;
    cycles = 0;
    valid_in = 1'b1;
    input_data = d;
    while (!acc && cycles < 200) begin
      if (rmode == 2) ready_out = 1'($urandom_range(0, 1));
      else ready_out = (rmode == 1);
      step(acc);
      cycles++;
    end
    if (!acc) chk("send_timeout", 64'(0), 64'(1));
    valid_in = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    int n;
    n = 0;
    valid_in = 1'b0;
    ready_out = 1'b1;
    while (exp_q.size() != 0 && n < 64) begin
      step(acc);
      n++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
    step(acc);
    step(acc);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid_in = 1'b0;
    exp_q.delete();
    wr_ord = 0;
    #1;
    chk("rst_ready_in", 64'(ready_in), 64'(1));
    chk("rst_valid_out", 64'(valid_out), 64'(0));
    chk("rst_output_data", 64'(output_data), 64'(0));
    chk("rst_last_out", 64'(last_out), 64'(0));
    chk("rst_frame_done", 64'(frame_done), 64'(0));
    chk("rst_frame_count", 64'(frame_count), 64'(0));
    chk("rst_fifo_count", 64'(fifo_count), 64'(0));
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  cyc;
    int  total;
    bit  acc;
    #2;
    do_reset();

    // Single element, visible one cycle after the write.
    send(32'h3F80_0000, 1, cyc);
    drain();

    // Fill past capacity with the sink stalled.
    for (int i = 0; i < 8; i++) send(elem_t'(i), 0, cyc);
    chk("fill_count", 64'(fifo_count), 64'(8));
    valid_in = 1'b1;
    input_data = 8;
    ready_out = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(acc);
      chk("full_stall", 64'(acc), 64'(0));
    end
    send(32'd8, 1, cyc);
    chk("accept_after_first_read", 64'(cyc), 64'(2));
    send(32'd9, 1, cyc);
    drain();

    // Framing at full rate from a clean frame boundary.
    do_reset();
    total = 0;
    for (int i = 0; i < 12; i++) begin
      send(elem_t'(100 + i), 1, cyc);
      total += cyc;
    end
    chk("full_rate_cycles", 64'(total), 64'(12));
    drain();
    chk("frames_after_12", 64'(frame_count), 64'(3));

    // Random valid/ready.
    for (int i = 0; i < 1000; i++) begin
      valid_in = 1'b0;
      while ($urandom_range(0, 1) == 1) begin
        ready_out = 1'($urandom_range(0, 1));
        step(acc);
      end
      send($urandom, 2, cyc);
    end
    drain();

    // Reset with a full FIFO and an upstream element stalled.
    do_reset();
    for (int i = 0; i < 8; i++) send(elem_t'(200 + i), 0, cyc);
    valid_in = 1'b1;
    input_data = 208;
    step(acc);
    do_reset();
    for (int i = 0; i < 4; i++) send(elem_t'(300 + i), 1, cyc);
    drain();
    chk("frames_after_reset", 64'(frame_count), 64'(1));

`ifdef ACT_STREAM_FRAMER_HWM_EN
    do_reset();
    for (int i = 0; i < 5; i++) send(elem_t'(400 + i), 0, cyc);
    drain();
    chk("hwm_after_5", 64'(hwm), 64'(5));
    hwm_clr = 1'b1;
    step(acc);
    hwm_clr = 1'b0;
    step(acc);
    chk("hwm_after_clr", 64'(hwm), 64'(0));
    for (int i = 0; i < 2; i++) send(elem_t'(500 + i), 0, cyc);
    step(acc);
    step(acc);
    chk("hwm_after_2", 64'(hwm), 64'(2));
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
